// File: rtl/rv32_pipeline_control_unit_pkg.sv
// rv32_pipeline_control_unit_pkg: control-field encodings, opcodes and the decoded bundle
package rv32_pipeline_control_unit_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4, RES_CSR} ResultSrc_t;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } AluControl_t;
  typedef enum logic [1:0] {SRCA_RS1, SRCA_PC, SRCA_ZERO} AluSrcA_t;
  typedef enum logic {SRCB_RS2, SRCB_IMM} AluSrcB_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} ImmSrc_t;
  typedef enum logic {PCT_PC, PCT_RS1} PCTargetSrc_t;
  typedef enum logic [1:0] {ST_SB, ST_SH, ST_SW} StoreOp_t;
  typedef enum logic [2:0] {LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU} LoadOp_t;
  typedef enum logic [1:0] {CSR_NONE, CSR_CYCLE, CSR_INSTRET} CsrOp_t;
  typedef struct packed {
    PCTargetSrc_t pc_target_src;
    ResultSrc_t   result_src;
    logic         mem_write;
    logic         jump;
    logic         branch;
    logic         reg_write;
    logic         csr_instr_inc;
    AluControl_t  alu_control;
    AluSrcA_t     alu_src_a;
    AluSrcB_t     alu_src_b;
    ImmSrc_t      imm_src;
    StoreOp_t     store_op;
    LoadOp_t      load_op;
    CsrOp_t       csr_op;
  } ctrl_t;
endpackage

// File: rtl/rv32_pipeline_control_unit_if.sv
// rv32_pipeline_control_unit_if: instruction fields, E-stage controls and D/E control bundles
// slave: the control unit (consumes fields, drives *D/*E); master: the surrounding pipeline
interface rv32_pipeline_control_unit_if;
  import rv32_pipeline_control_unit_pkg::*;
  logic [6:0] opD;
  logic [2:0] funct3D;
  logic funct7b5D, funct7b1D, immb10D, FlushE, halt;
  PCTargetSrc_t PCTargetSrcD, PCTargetSrcE;
  ResultSrc_t ResultSrcD, ResultSrcE;
  logic MemWriteD, MemWriteE, JumpD, JumpE, BranchD, BranchE;
  logic RegWriteD, RegWriteE, CsrInstrIncD, CsrInstrIncE;
  AluControl_t AluControlD, AluControlE;
  AluSrcA_t AluSrcAD, AluSrcAE;
  AluSrcB_t AluSrcBD, AluSrcBE;
  ImmSrc_t ImmSrcD, ImmSrcE;
  StoreOp_t StoreOpD, StoreOpE;
  LoadOp_t LoadOpD, LoadOpE;
  CsrOp_t CsrOpD, CsrOpE;
  modport slave (
    input  opD, funct3D, funct7b5D, funct7b1D, immb10D, FlushE, halt,
    output PCTargetSrcD, ResultSrcD, MemWriteD, JumpD, BranchD, RegWriteD, CsrInstrIncD,
           AluControlD, AluSrcAD, AluSrcBD, ImmSrcD, StoreOpD, LoadOpD, CsrOpD,
           PCTargetSrcE, ResultSrcE, MemWriteE, JumpE, BranchE, RegWriteE, CsrInstrIncE,
           AluControlE, AluSrcAE, AluSrcBE, ImmSrcE, StoreOpE, LoadOpE, CsrOpE
  );
  modport master (
    output opD, funct3D, funct7b5D, funct7b1D, immb10D, FlushE, halt,
    input  PCTargetSrcD, ResultSrcD, MemWriteD, JumpD, BranchD, RegWriteD, CsrInstrIncD,
           AluControlD, AluSrcAD, AluSrcBD, ImmSrcD, StoreOpD, LoadOpD, CsrOpD,
           PCTargetSrcE, ResultSrcE, MemWriteE, JumpE, BranchE, RegWriteE, CsrInstrIncE,
           AluControlE, AluSrcAE, AluSrcBE, ImmSrcE, StoreOpE, LoadOpE, CsrOpE
  );
endinterface

// File: rtl/rv32_pipeline_control_unit_alu_decoder.sv
// rv32_pipeline_control_unit_alu_decoder: opcode/funct fields -> ALU/compare operation
// ports: op_i, funct3_i, funct7b5_i, funct7b1_i in; alu_control_o out
module rv32_pipeline_control_unit_alu_decoder
  import rv32_pipeline_control_unit_pkg::*;
(
  input  logic [6:0]  op_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic        funct7b1_i,
  output AluControl_t alu_control_o
);
  always_comb begin
    alu_control_o = ALU_ADD;
    if (op_i == OPC_OP && funct7b1_i)
      alu_control_o = AluControl_t'(5'd16 + {2'b00, funct3_i});
    else if (op_i == OPC_OP || op_i == OPC_OPIMM)
      case (funct3_i)
        3'd0: alu_control_o = (op_i == OPC_OP && funct7b5_i) ? ALU_SUB : ALU_ADD;
        3'd1: alu_control_o = ALU_SLL;
        3'd2: alu_control_o = ALU_SLT;
        3'd3: alu_control_o = ALU_SLTU;
        3'd4: alu_control_o = ALU_XOR;
        3'd5: alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
        3'd6: alu_control_o = ALU_OR;
        default: alu_control_o = ALU_AND;
      endcase
    else if (op_i == OPC_BRANCH)
      case (funct3_i)
        3'd0: alu_control_o = ALU_BEQ;
        3'd1: alu_control_o = ALU_BNE;
        3'd4: alu_control_o = ALU_BLT;
        3'd5: alu_control_o = ALU_BGE;
        3'd6: alu_control_o = ALU_BLTU;
        3'd7: alu_control_o = ALU_BGEU;
        default: alu_control_o = ALU_ADD;
      endcase
  end
endmodule

// File: rtl/rv32_pipeline_control_unit.sv
// rv32_pipeline_control_unit: RV32IM+Zicsr main decoder with the ID/EX control register
// ports: clk, resetn (async, active-low), bus (slave: fields in, *D and *E bundles out)
module rv32_pipeline_control_unit
  import rv32_pipeline_control_unit_pkg::*;
(
  input logic clk,
  input logic resetn,
  rv32_pipeline_control_unit_if.slave bus
);
  ctrl_t dec, ctrl_d, ctrl_q;
  AluControl_t alu_ctrl;
  logic [2:0] f3;
  assign f3 = bus.funct3D;
  rv32_pipeline_control_unit_alu_decoder u_alu_dec (
    .op_i(bus.opD), .funct3_i(f3), .funct7b5_i(bus.funct7b5D),
    .funct7b1_i(bus.funct7b1D), .alu_control_o(alu_ctrl)
  );
  // Unrecognized opcodes and funct3 values leave the whole bundle at zero.
  always_comb begin
    dec = '0;
    case (bus.opD)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        dec.csr_instr_inc = 1'b1;
        dec.alu_control = alu_ctrl;
      end
      OPC_OPIMM: begin
        dec.reg_write = 1'b1;
        dec.csr_instr_inc = 1'b1;
        dec.alu_control = alu_ctrl;
        dec.alu_src_b = SRCB_IMM;
      end
      OPC_LOAD: if (f3 != 3'd3 && f3 < 3'd6) begin
        dec.reg_write = 1'b1;
        dec.csr_instr_inc = 1'b1;
        dec.alu_src_b = SRCB_IMM;
        dec.result_src = RES_MEM;
        dec.load_op = f3[2] ? LoadOp_t'(3'd3 + {2'b00, f3[0]}) : LoadOp_t'({1'b0, f3[1:0]});
      end
      OPC_STORE: if (f3 < 3'd3) begin
        dec.mem_write = 1'b1;
        dec.csr_instr_inc = 1'b1;
        dec.alu_src_b = SRCB_IMM;
        dec.imm_src = IMM_S;
        dec.store_op = StoreOp_t'(f3[1:0]);
      end
      OPC_BRANCH: if (f3[2:1] != 2'b01) begin
        dec.branch = 1'b1;
        dec.csr_instr_inc = 1'b1;
        dec.imm_src = IMM_B;
        dec.alu_control = alu_ctrl;
      end
      OPC_JAL: begin
        dec.jump = 1'b1;
        dec.csr_instr_inc = 1'b1;
        dec.imm_src = IMM_J;
        dec.result_src = RES_PC4;
        dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        dec.jump = 1'b1;
        dec.csr_instr_inc = 1'b1;
        dec.alu_src_b = SRCB_IMM;
        dec.pc_target_src = PCT_RS1;
        dec.result_src = RES_PC4;
        dec.reg_write = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.alu_src_a = (bus.opD == OPC_LUI) ? SRCA_ZERO : SRCA_PC;
        dec.alu_src_b = SRCB_IMM;
        dec.imm_src = IMM_U;
        dec.reg_write = 1'b1;
        dec.csr_instr_inc = 1'b1;
      end
      OPC_SYSTEM: if (f3 == 3'd2) begin
        dec.csr_op = bus.immb10D ? CSR_INSTRET : CSR_CYCLE;
        dec.result_src = RES_CSR;
        dec.reg_write = 1'b1;
        dec.csr_instr_inc = 1'b1;
      end
      default: dec = '0;
    endcase
  end
  // Flush wins over halt so a bubble can be forced into a frozen E stage.
  assign ctrl_d = bus.FlushE ? '0 : bus.halt ? ctrl_q : dec;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ctrl_q <= '0;
    else ctrl_q <= ctrl_d;
  assign bus.PCTargetSrcD = dec.pc_target_src;
  assign bus.ResultSrcD   = dec.result_src;
  assign bus.MemWriteD    = dec.mem_write;
  assign bus.JumpD        = dec.jump;
  assign bus.BranchD      = dec.branch;
  assign bus.RegWriteD    = dec.reg_write;
  assign bus.CsrInstrIncD = dec.csr_instr_inc;
  assign bus.AluControlD  = dec.alu_control;
  assign bus.AluSrcAD     = dec.alu_src_a;
  assign bus.AluSrcBD     = dec.alu_src_b;
  assign bus.ImmSrcD      = dec.imm_src;
  assign bus.StoreOpD     = dec.store_op;
  assign bus.LoadOpD      = dec.load_op;
  assign bus.CsrOpD       = dec.csr_op;
  assign bus.PCTargetSrcE = ctrl_q.pc_target_src;
  assign bus.ResultSrcE   = ctrl_q.result_src;
  assign bus.MemWriteE    = ctrl_q.mem_write;
  assign bus.JumpE        = ctrl_q.jump;
  assign bus.BranchE      = ctrl_q.branch;
  assign bus.RegWriteE    = ctrl_q.reg_write;
  assign bus.CsrInstrIncE = ctrl_q.csr_instr_inc;
  assign bus.AluControlE  = ctrl_q.alu_control;
  assign bus.AluSrcAE     = ctrl_q.alu_src_a;
  assign bus.AluSrcBE     = ctrl_q.alu_src_b;
  assign bus.ImmSrcE      = ctrl_q.imm_src;
  assign bus.StoreOpE     = ctrl_q.store_op;
  assign bus.LoadOpE      = ctrl_q.load_op;
  assign bus.CsrOpE       = ctrl_q.csr_op;
endmodule

// File: tb/tb_rv32_pipeline_control_unit.sv
// tb_rv32_pipeline_control_unit: directed and random checks of decode bundle and E register
module tb_rv32_pipeline_control_unit;
  typedef struct {
    int pcts, res, mw, j, br, rw, inc, alu, sa, sb, imm, so, lo, csr;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t zero, exp_d, exp_e;
  rv32_pipeline_control_unit_if bus();
  rv32_pipeline_control_unit dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic exp_t model(logic [6:0] op, logic [2:0] f3, logic b5, logic b1, logic b10);
    exp_t e = '{default: 0};
    int base[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    int brc[8] = '{10, 11, -1, -1, 12, 13, 14, 15};
    int ldc[8] = '{0, 1, 2, -1, 3, 4, -1, -1};
    int i = int'(f3);
    case (op)
      7'h33: begin e.rw = 1; e.inc = 1; e.alu = b1 ? 16 + i : base[i] + ((b5 && (i == 0 || i == 5)) ? 1 : 0); end
      7'h13: begin e.rw = 1; e.inc = 1; e.sb = 1; e.alu = base[i] + ((b5 && i == 5) ? 1 : 0); end
      7'h03: if (ldc[i] >= 0) begin e.rw = 1; e.inc = 1; e.sb = 1; e.res = 1; e.lo = ldc[i]; end
      7'h23: if (i < 3) begin e.mw = 1; e.inc = 1; e.sb = 1; e.imm = 1; e.so = i; end
      7'h63: if (brc[i] >= 0) begin e.br = 1; e.inc = 1; e.imm = 2; e.alu = brc[i]; end
      7'h6F: begin e.j = 1; e.inc = 1; e.imm = 3; e.res = 2; e.rw = 1; end
      7'h67: begin e.j = 1; e.inc = 1; e.sb = 1; e.pcts = 1; e.res = 2; e.rw = 1; end
      7'h37: begin e.sa = 2; e.sb = 1; e.imm = 4; e.rw = 1; e.inc = 1; end
      7'h17: begin e.sa = 1; e.sb = 1; e.imm = 4; e.rw = 1; e.inc = 1; end
      7'h73: if (i == 2) begin e.csr = b10 ? 2 : 1; e.res = 3; e.rw = 1; e.inc = 1; end
      default: ;
    endcase
    return e;
  endfunction
  task automatic check_d(string t, exp_t e);
    chk({t, "_pcts"}, int'(bus.PCTargetSrcD), e.pcts);
    chk({t, "_res"}, int'(bus.ResultSrcD), e.res);
    chk({t, "_mw"}, int'(bus.MemWriteD), e.mw);
    chk({t, "_j"}, int'(bus.JumpD), e.j);
    chk({t, "_br"}, int'(bus.BranchD), e.br);
    chk({t, "_rw"}, int'(bus.RegWriteD), e.rw);
    chk({t, "_inc"}, int'(bus.CsrInstrIncD), e.inc);
    chk({t, "_alu"}, int'(bus.AluControlD), e.alu);
    chk({t, "_sa"}, int'(bus.AluSrcAD), e.sa);
    chk({t, "_sb"}, int'(bus.AluSrcBD), e.sb);
    chk({t, "_imm"}, int'(bus.ImmSrcD), e.imm);
    chk({t, "_so"}, int'(bus.StoreOpD), e.so);
    chk({t, "_lo"}, int'(bus.LoadOpD), e.lo);
    chk({t, "_csr"}, int'(bus.CsrOpD), e.csr);
  endtask
  task automatic check_e(string t, exp_t e);
    chk({t, "_pctsE"}, int'(bus.PCTargetSrcE), e.pcts);
    chk({t, "_resE"}, int'(bus.ResultSrcE), e.res);
    chk({t, "_mwE"}, int'(bus.MemWriteE), e.mw);
    chk({t, "_jE"}, int'(bus.JumpE), e.j);
    chk({t, "_brE"}, int'(bus.BranchE), e.br);
    chk({t, "_rwE"}, int'(bus.RegWriteE), e.rw);
    chk({t, "_incE"}, int'(bus.CsrInstrIncE), e.inc);
    chk({t, "_aluE"}, int'(bus.AluControlE), e.alu);
    chk({t, "_saE"}, int'(bus.AluSrcAE), e.sa);
    chk({t, "_sbE"}, int'(bus.AluSrcBE), e.sb);
    chk({t, "_immE"}, int'(bus.ImmSrcE), e.imm);
    chk({t, "_soE"}, int'(bus.StoreOpE), e.so);
    chk({t, "_loE"}, int'(bus.LoadOpE), e.lo);
    chk({t, "_csrE"}, int'(bus.CsrOpE), e.csr);
  endtask
  task automatic drive(logic [6:0] op, logic [2:0] f3, logic b5, logic b1, logic b10, string t);
    bus.opD = op;
    bus.funct3D = f3;
    bus.funct7b5D = b5;
    bus.funct7b1D = b1;
    bus.immb10D = b10;
    #1;
    exp_d = model(op, f3, b5, b1, b10);
    check_d(t, exp_d);
  endtask
  task automatic apply(logic [31:0] ins, logic b10, string t);
    drive(ins[6:0], ins[14:12], ins[30], ins[25], b10, t);
  endtask
  task automatic step(string t);
    logic f, h;
    f = bus.FlushE;
    h = bus.halt;
    @(posedge clk);
    exp_e = f ? zero : h ? exp_e : exp_d;
    @(negedge clk);
    check_e(t, exp_e);
  endtask
  initial begin
    int opc[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    zero = '{default: 0};
    bus.FlushE = 1'b0;
    bus.halt = 1'b0;
    drive(7'h00, 3'd0, 1'b0, 1'b0, 1'b0, "rst_d");
    #12;
    check_e("rst", zero);
    @(negedge clk);
    resetn = 1'b1;
    exp_e = zero;
    apply(32'h40208033, 1'b0, "sub");
    chk("sub_alu", int'(bus.AluControlD), 1);
    chk("sub_rw", int'(bus.RegWriteD), 1);
    chk("sub_sb", int'(bus.AluSrcBD), 0);
    step("sub");
    chk("sub_aluE_lat", int'(bus.AluControlE), 1);
    apply(32'h02208033, 1'b0, "mul");
    chk("mul_alu", int'(bus.AluControlD), 16);
    apply(32'h0220C033, 1'b0, "div");
    chk("div_alu", int'(bus.AluControlD), 20);
    apply(32'h00012083, 1'b0, "lw");
    chk("lw_res", int'(bus.ResultSrcD), 1);
    chk("lw_lo", int'(bus.LoadOpD), 2);
    chk("lw_sb", int'(bus.AluSrcBD), 1);
    chk("lw_imm", int'(bus.ImmSrcD), 0);
    apply(32'h00209023, 1'b0, "sh");
    chk("sh_mw", int'(bus.MemWriteD), 1);
    chk("sh_so", int'(bus.StoreOpD), 1);
    chk("sh_rw", int'(bus.RegWriteD), 0);
    apply(32'h00208463, 1'b0, "beq");
    chk("beq_br", int'(bus.BranchD), 1);
    chk("beq_alu", int'(bus.AluControlD), 10);
    chk("beq_imm", int'(bus.ImmSrcD), 2);
    apply(32'hC0002073, 1'b0, "cycle");
    chk("cycle_csr", int'(bus.CsrOpD), 1);
    chk("cycle_res", int'(bus.ResultSrcD), 3);
    apply(32'hC0002073, 1'b1, "instret");
    chk("instret_csr", int'(bus.CsrOpD), 2);
    apply(32'h0000007F, 1'b0, "bad");
    chk("bad_rw", int'(bus.RegWriteD), 0);
    chk("bad_inc", int'(bus.CsrInstrIncD), 0);
    apply(32'h000080E7, 1'b0, "jalr");
    chk("jalr_j", int'(bus.JumpD), 1);
    chk("jalr_pcts", int'(bus.PCTargetSrcD), 1);
    chk("jalr_res", int'(bus.ResultSrcD), 2);
    step("jalr");
    #2;
    resetn = 1'b0;
    #1;
    exp_e = zero;
    check_e("async_rst", zero);
    @(negedge clk);
    resetn = 1'b1;
    apply(32'h00012083, 1'b0, "lw2");
    step("lw2");
    bus.halt = 1'b1;
    apply(32'h00208463, 1'b0, "h1");
    step("h1");
    apply(32'h000080E7, 1'b0, "h2");
    step("h2");
    apply(32'hC0002073, 1'b1, "h3");
    step("h3");
    chk("halt_resE", int'(bus.ResultSrcE), 1);
    chk("halt_loE", int'(bus.LoadOpE), 2);
    bus.FlushE = 1'b1;
    step("flush_halt");
    chk("flush_rwE", int'(bus.RegWriteE), 0);
    bus.FlushE = 1'b0;
    bus.halt = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'(opc[$urandom_range(0, 9)]);
      f3 = (op == 7'h67) ? 3'd0 : 3'($urandom);
      bus.FlushE = ($urandom_range(0, 9) == 0);
      bus.halt = ($urandom_range(0, 4) == 0);
      drive(op, f3, 1'($urandom), 1'($urandom), 1'($urandom), "rnd");
      step("rnd");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32_pipeline_control_unit.md
Name: rv32_pipeline_control_unit

Overview:
- RV32IM + Zicsr counter-read instruction decoder for the 5-stage pipelined core.
- Combinationally decodes the Decode-stage instruction fields into a control bundle (the *D outputs).
- Registers that bundle into the Execute stage (the *E outputs), with flush and stall.
- Sits between the IF/ID register and the datapath's ID/EX register.

Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- opD  in  7  InstrD[6:0]
- funct3D  in  3  InstrD[14:12]
- funct7b5D  in  1  InstrD[30]
- funct7b1D  in  1  InstrD[25]; selects the M extension
- immb10D  in  1  CSR select bit: 0 = cycle, 1 = instret
- FlushE  in  1  synchronous bubble insert into E
- halt  in  1  freeze E register
- PCTargetSrcD  out  1  0 = PC+imm, 1 = rs1+imm (JALR)
- ResultSrcD  out  2  0 ALU, 1 MEM, 2 PC+4, 3 CSR
- MemWriteD, JumpD, BranchD, RegWriteD, CsrInstrIncD  out  1 each
- AluControlD  out  5  ALU/compare operation
- AluSrcAD  out  2  0 rs1, 1 PC, 2 zero
- AluSrcBD  out  1  0 rs2, 1 imm
- ImmSrcD  out  3  0 I, 1 S, 2 B, 3 J, 4 U
- StoreOpD  out  2  0 SB, 1 SH, 2 SW
- LoadOpD  out  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU
- CsrOpD  out  2  0 none, 1 cycle, 2 instret
- Every *D output has a registered *E output of identical width and encoding.

Behaviour:
- AluControl codes 0..23, in order: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU BEQ BNE BLT BGE BLTU BGEU MUL MULH MULHSU MULHU DIV DIVU REM REMU.
- OP (0110011), funct7b1=0: funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7b5=1 turns ADD into SUB and SRL into SRA. RegWrite=1, SrcA=rs1, SrcB=rs2, Result=ALU.
- OP, funct7b1=1: funct3 0..7 selects MUL..REMU in code order; funct7b5 ignored.
- OP-IMM (0010011): as OP but SrcB=imm, ImmSrc=I. funct7b5 considered only for funct3=101 (SRAI); ADDI never subtracts.
- LOAD (0000011): ADD, SrcB=imm, ImmSrc=I, Result=MEM, RegWrite=1. LoadOp from funct3: 000→LB, 001→LH, 010→LW, 100→LBU, 101→LHU.
- STORE (0100011): ADD, SrcB=imm, ImmSrc=S, MemWrite=1, RegWrite=0. StoreOp from funct3: 000/001/010.
- BRANCH (1100011): Branch=1, ImmSrc=B, SrcB=rs2, PCTargetSrc=0. AluControl from funct3: BEQ BNE - - BLT BGE BLTU BGEU.
- JAL (1101111): Jump=1, ImmSrc=J, Result=PC+4, RegWrite=1, PCTargetSrc=0.
- JALR (1100111): Jump=1, ImmSrc=I, SrcA=rs1, SrcB=imm, ADD, PCTargetSrc=1, Result=PC+4, RegWrite=1.
- LUI (0110111): SrcA=zero, SrcB=imm, ImmSrc=U, ADD, RegWrite=1.
- AUIPC (0010111): as LUI but SrcA=PC.
- SYSTEM (1110011), funct3=010: CsrOp = immb10 ? 2 : 1, Result=CSR, RegWrite=1. Other funct3 → CsrOp=0 and no writes.
- CsrInstrIncD=1 for every recognized opcode; 0 otherwise.
- Unrecognized opcode or funct3: RegWrite, MemWrite, Jump, Branch, CsrInstrInc all 0; remaining fields 0.
- E register priority: resetn low (async) → all *E = 0. Else FlushE → all *E = 0 (bubble) at the clock edge. Else halt → hold. Else load the *D bundle.
- Latency: D outputs are combinational, 0 cycles; E outputs lag by 1 cycle.

Decomposition:
- Shared package holds ResultSrc_t, AluControl_t, AluSrcA_t, AluSrcB_t, ImmSrc_t, PCTargetSrc_t, StoreOp_t, LoadOp_t, CsrOp_t, plus opcode constants.
- One sub-module, alu_decoder (opD, funct3D, funct7b5D, funct7b1D → AluControl).
- Main decoder and E register live in the top.

Test Plan:
- 0x40208033 (sub) → AluControlD=1, RegWriteD=1, AluSrcBD=0; next edge AluControlE=1.
- 0x02208033 (mul) → AluControlD=16; 0x0220C033 (div) → 20.
- 0x00012083 (lw) → ResultSrcD=1, LoadOpD=2, AluSrcBD=1, ImmSrcD=0; 0x00209023 (sh) → MemWriteD=1, StoreOpD=1, RegWriteD=0.
- 0x00208463 (beq) → BranchD=1, AluControlD=10, ImmSrcD=2; 0x000080E7 (jalr) → JumpD=1, PCTargetSrcD=1, ResultSrcD=2.
- 0xC0002073 with immb10D=0 → CsrOpD=1, ResultSrcD=3; immb10D=1 → CsrOpD=2. Opcode 0x7F → all enables 0, CsrInstrIncD=0.
- Reset and E-register control:
  - Assert resetn low mid-cycle → *E clear immediately.
  - FlushE with halt both high → *E=0.
  - halt alone → *E held over 3 cycles while *D changes.
